// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: command byte selects read/write and start address,
// following bytes burst through seven writable registers plus a live status slot.
module spi_reg_bank #(
  parameter logic [7:0] REG_RST     = 8'h00,
  parameter logic [2:0] STATUS_ADDR = 3'd7
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        ss,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [7:0]  status_in,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic [55:0] reg_out,
  output logic        wr_strobe,
  output logic        err
);

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 7;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_load_q, tx_load_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic            err_q, err_d;
  logic [AW-1:0]   rd_addr_c;
  logic [DW-1:0]   rd_val_c;

  // Read source: the command byte carries the address, later bytes use ptr.
  always_comb begin
    rd_addr_c = (state_q == CMD) ? rx_data[AW-1:0] : ptr_q;
    rd_val_c  = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rd_addr_c == AW'(i)) rd_val_c = regs_q[i];
    end
    if (rd_addr_c == STATUS_ADDR) rd_val_c = status_in;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    wr_strobe_d = 1'b0;
    err_d       = err_q;
    // Frame deselect wins over any byte arriving in the same cycle.
    if (!ss) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CMD;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
        CMD: begin
          if (rx_valid) begin
            ptr_d = rx_data[AW-1:0];
            if (rx_data[7]) begin
              state_d = WRITE;
            end else begin
              state_d   = READ;
              tx_data_d = rd_val_c;
              tx_load_d = 1'b1;
              ptr_d     = rx_data[AW-1:0] + AW'(1);
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            if (ptr_q == STATUS_ADDR) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < int'(NREG); i++) begin
                if (ptr_q == AW'(i)) begin
                  regs_d[i]   = rx_data;
                  wr_strobe_d = 1'b1;
                end
              end
            end
            ptr_d = ptr_q + AW'(1);
          end
        end
        READ: begin
          if (rx_valid) begin
            tx_data_d = rd_val_c;
            tx_load_d = 1'b1;
            ptr_d     = ptr_q + AW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      regs_q      <= '{default: REG_RST};
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      wr_strobe_q <= wr_strobe_d;
      err_q       <= err_d;
    end
  end

  for (genvar g = 0; g < int'(NREG); g++) begin : g_flat
    assign reg_out[DW*g +: DW] = regs_q[g];
  end

  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign wr_strobe = wr_strobe_q;
  assign err       = err_q;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter REG_RST, default 8'h00: reset value of writable registers 0..6.
REQ-002 Parameter STATUS_ADDR, default 3'd7: address of the read-only status register.
REQ-003 sys_clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ss  input  1  frame select, already synchronised to sys_clk; high = frame active.
REQ-006 rx_data  input  8  byte received from the SPI slave shift stage.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-008 status_in  input  8  live status value returned on reads of STATUS_ADDR.
REQ-009 tx_data  output  8  byte for the SPI slave to shift out on the next byte slot.
REQ-010 tx_load  output  1  one-cycle strobe; tx_data updated and must be latched by the slave.
REQ-011 reg_out  output  56  registers 0..6 flattened; reg n at bits [8n+7:8n].
REQ-012 wr_strobe  output  1  one-cycle pulse on every committed register write.
REQ-013 err  output  1  sticky frame error flag.

Function
REQ-014 FSM states: IDLE, CMD, WRITE, READ; state and all outputs registered.
REQ-015 IDLE -> CMD on a sys_clk edge with ss=1; any state -> IDLE on an edge with ss=0; ss=0 has priority over rx_valid in the same cycle, and that byte is discarded.
REQ-016 Entry to CMD clears err and the address pointer (ptr, 3 bits).
REQ-017 rx_valid in IDLE is ignored with no state or output change.
REQ-018 In CMD, rx_valid decodes rx_data: bit7=1 write, bit7=0 read; bits[2:0] load ptr; bits[6:3] ignored.
REQ-019 Write command -> WRITE; no register changes on the command byte.
REQ-020 Read command -> READ; next cycle tx_data = value at rx_data[2:0], tx_load=1 for one cycle, ptr = rx_data[2:0]+1.
REQ-021 In WRITE, each rx_valid with ptr != STATUS_ADDR writes rx_data to reg[ptr] and pulses wr_strobe the following cycle.
REQ-022 In WRITE, rx_valid with ptr == STATUS_ADDR leaves all registers unchanged, produces no wr_strobe, and sets err.
REQ-023 In WRITE, ptr increments modulo 8 after every rx_valid, including rejected bytes.
REQ-024 In READ, each rx_valid (dummy byte) loads tx_data with the value at ptr, pulses tx_load the following cycle, and increments ptr modulo 8.
REQ-025 The value at STATUS_ADDR is status_in sampled in the cycle rx_valid is seen; addresses 0..6 return reg_out contents.
REQ-026 Latency: rx_valid at edge N yields the register update, wr_strobe, tx_load and tx_data at edge N+1; consecutive rx_valid on back-to-back cycles is supported.
REQ-027 ptr wraps 7 -> 0 in both WRITE and READ; bursts of any length are legal.
REQ-028 tx_data holds its last value between tx_load pulses and across frames.
REQ-029 reg_out retains its values across frames; only rst restores REG_RST.
REQ-030 err stays set until the next CMD entry or rst; it is not cleared on return to IDLE.

Reset
REQ-031 rst=1 forces IDLE, ptr=0, reg_out = seven copies of REG_RST, tx_data=8'h00, tx_load=0, wr_strobe=0, err=0, immediately and without waiting for a clock edge.
REQ-032 rst asserted mid-frame aborts the frame; after release the FSM remains in IDLE until a clock edge sees ss=1.

Verification
REQ-033 After reset, frame of bytes 8'h82, 8'hA5, 8'h5A -> reg2=A5, reg3=5A, two wr_strobe pulses, err=0.
REQ-034 Preload reg2=A5 and reg3=5A; read frame 8'h02 then two dummies -> tx_data sequence A5, 5A, reg4, three tx_load pulses, each one cycle after its rx_valid.
REQ-035 Write frame 8'h86 then 11, 22, 33 -> reg6=11, status write rejected with err=1, reg0=33, two wr_strobe pulses; the next frame start clears err.
REQ-036 status_in=C3; read frame 8'h07 -> tx_data=C3; first dummy -> tx_data=reg0 (wrap).
REQ-037 ss drops in the same cycle as rx_valid in WRITE -> no write, no wr_strobe, state IDLE.
REQ-038 rst pulsed mid-burst with no clock edge -> all outputs at reset values immediately and the following bytes ignored until a new frame starts.
